// File: rtl/ub_tile_sequencer_if.sv
// Host/unified-buffer side bundle for ub_tile_sequencer.
// master = host + accumulators driving the sequencer; slave = the sequencer itself.
interface ub_tile_sequencer_if #(
  parameter int ADDR_W = 13,
  parameter int TILE_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] in_base;
  logic [ADDR_W-1:0] out_base;
  logic [TILE_W-1:0] num_tiles;
  logic              store_acc1;
  logic              store_acc2;
  logic [ADDR_W-1:0] ub_addr;
  logic              ub_load_input;
  logic              ub_store;
  logic              busy;
  logic              done;
  logic              error;
  logic [TILE_W-1:0] tile_idx;

  modport master (
    output start, in_base, out_base, num_tiles, store_acc1, store_acc2,
    input  ub_addr, ub_load_input, ub_store, busy, done, error, tile_idx
  );

  modport slave (
    input  start, in_base, out_base, num_tiles, store_acc1, store_acc2,
    output ub_addr, ub_load_input, ub_store, busy, done, error, tile_idx
  );
endinterface

// File: rtl/ub_tile_sequencer.sv
// Unified-buffer tile sequencer: per tile, one load burst, wait for both accumulators full, one store burst.
// Define UB_SEQ_TIMEOUT_EN to add a WAIT watchdog with an ERR state and sticky error flag.
module ub_tile_sequencer #(
  parameter int ADDR_W  = 13,
  parameter int TILE_W  = 8,
  parameter int STRIDE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  ub_tile_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_STORE,
    S_DONE
`ifdef UB_SEQ_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_in_ptr;
  logic [ADDR_W-1:0] r_out_ptr;
  logic [TILE_W-1:0] r_cnt;
  logic [TILE_W-1:0] r_tile_idx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_load;
  logic              r_store;
  logic              r_busy;
  logic              r_done;

  logic              w_flags;
  logic              w_last;
  logic [ADDR_W-1:0] w_step;

`ifdef UB_SEQ_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] r_wait_cnt;
  logic          r_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  assign w_flags = bus.store_acc1 && bus.store_acc2;
  assign w_last  = (r_tile_idx == (r_cnt - TILE_W'(1)));
  assign w_step  = ADDR_W'(STRIDE);

  // Outputs are written on the transition into the state that owns them,
  // so each strobe is a register that is high exactly for that state's cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_ptr   <= '0;
      r_out_ptr  <= '0;
      r_cnt      <= '0;
      r_tile_idx <= '0;
      r_addr     <= '0;
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UB_SEQ_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
`ifdef UB_SEQ_TIMEOUT_EN
        S_IDLE, S_ERR: begin
`else
        S_IDLE: begin
`endif
          if (bus.start) begin
`ifdef UB_SEQ_TIMEOUT_EN
            r_error <= 1'b0;
`endif
            r_busy <= 1'b1;
            if (bus.num_tiles != '0) begin
              r_in_ptr   <= bus.in_base;
              r_out_ptr  <= bus.out_base;
              r_cnt      <= bus.num_tiles;
              r_tile_idx <= '0;
              r_addr     <= bus.in_base;
              r_load     <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_LOAD: begin
          r_in_ptr <= r_in_ptr + w_step;
          r_addr   <= r_out_ptr;
          r_state  <= S_WAIT;
`ifdef UB_SEQ_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end

        S_WAIT: begin
          if (w_flags) begin
            r_store <= 1'b1;
            r_state <= S_STORE;
          end
`ifdef UB_SEQ_TIMEOUT_EN
          else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
`endif
        end

        S_STORE: begin
          r_out_ptr <= r_out_ptr + w_step;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // in_ptr already advanced during LOAD, so it points at the next tile
            r_tile_idx <= r_tile_idx + TILE_W'(1);
            r_addr     <= r_in_ptr;
            r_load     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ub_addr       = r_addr;
  assign bus.ub_load_input = r_load;
  assign bus.ub_store      = r_store;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.tile_idx      = r_tile_idx;
`ifdef UB_SEQ_TIMEOUT_EN
  assign bus.error         = r_error;
`else
  assign bus.error         = 1'b0;
`endif

endmodule
